// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between the command controller and its neighbours (UART RX, RegFile, ALU, TX FIFO).
// Strobe semantics: RX_D_VLD, RdData_valid, OUT_valid, WrEN, ALU_EN, WR_INC and CMD_ERR are
// single-cycle qualifiers sampled on the rising clock edge; WR_INC is only raised while FIFO_FULL=0.
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_valid;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_valid;
  logic                    FIFO_FULL;
  logic                    WrEN;
  logic                    RdEN;
  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   WrData;
  logic                    ALU_EN;
  logic [3:0]              ALU_FUN;
  logic                    CLKG_EN;
  logic                    CLKDIV_EN;
  logic [DATA_WIDTH-1:0]   WR_DATA_FIFO;
  logic                    WR_INC;
  logic                    CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_valid, ALU_OUT, OUT_valid, FIFO_FULL,
    output WrEN, RdEN, Address, WrData, ALU_EN, ALU_FUN, CLKG_EN, CLKDIV_EN,
           WR_DATA_FIFO, WR_INC, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_valid, ALU_OUT, OUT_valid, FIFO_FULL,
    input  WrEN, RdEN, Address, WrData, ALU_EN, ALU_FUN, CLKG_EN, CLKDIV_EN,
           WR_DATA_FIFO, WR_INC, CMD_ERR
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Command frame parser: decodes RX bytes into RegFile/ALU operations and serialises the
// responses into the TX FIFO, with backpressure, frame timeout and error pulses.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  sys_cmd_ctrl_if.master       bus,
  output logic [3:0]           o_dbg_state
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [DW-1:0] OP_WR  = DW'(8'hAA);
  localparam logic [DW-1:0] OP_RD  = DW'(8'hBB);
  localparam logic [DW-1:0] OP_CC  = DW'(8'hCC);
  localparam logic [DW-1:0] OP_DD  = DW'(8'hDD);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_A    = 4'd5,
    ST_ALU_B    = 4'd6,
    ST_ALU_FUN  = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_LO    = 4'd9,
    ST_TX_HI    = 4'd10
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic [2*DW-1:0]   r_tx_buf;
  logic              r_tx_two;
  logic [TW-1:0]     r_to_cnt;

  logic              r_wr_en;
  logic              r_rd_en;
  logic [AW-1:0]     r_address;
  logic [DW-1:0]     r_wr_data;
  logic              r_alu_en;
  logic [3:0]        r_alu_fun;
  logic              r_clkg_en;
  logic              r_clkdiv_en;
  logic [DW-1:0]     r_fifo_data;
  logic              r_wr_inc;
  logic              r_cmd_err;

  logic              w_wait_state;
  logic              w_busy_state;
  logic              w_progress;
  logic              w_timeout;

  always_comb begin
    w_wait_state = 1'b0;
    w_busy_state = 1'b0;
    w_progress   = 1'b0;
    case (r_state)
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_ALU_A, ST_ALU_B, ST_ALU_FUN: begin
        w_wait_state = 1'b1;
        w_progress   = bus.RX_D_VLD;
      end
      ST_RD_WAIT: begin
        w_wait_state = 1'b1;
        w_busy_state = 1'b1;
        w_progress   = bus.RdData_valid;
      end
      ST_ALU_WAIT: begin
        w_wait_state = 1'b1;
        w_busy_state = 1'b1;
        w_progress   = bus.OUT_valid;
      end
      ST_TX_LO, ST_TX_HI: w_busy_state = 1'b1;
      default: ;
    endcase
  end

  // A zero TIMEOUT_CYC removes the abort path entirely.
  assign w_timeout = (TIMEOUT_CYC != 0) && w_wait_state && !w_progress &&
                     (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_tx_buf    <= '0;
      r_tx_two    <= 1'b0;
      r_to_cnt    <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_address   <= '0;
      r_wr_data   <= '0;
      r_alu_en    <= 1'b0;
      r_alu_fun   <= '0;
      r_clkg_en   <= 1'b0;
      r_clkdiv_en <= 1'b1;
      r_fifo_data <= '0;
      r_wr_inc    <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_wr_inc  <= 1'b0;
      r_cmd_err <= 1'b0;

      if (w_wait_state && !w_progress) r_to_cnt <= r_to_cnt + 1'b1;
      else                             r_to_cnt <= '0;

      // Bytes that arrive while a response is pending are discarded and flagged.
      if (bus.RX_D_VLD && w_busy_state) r_cmd_err <= 1'b1;

      if (w_timeout) begin
        r_cmd_err <= 1'b1;
        r_clkg_en <= 1'b0;
        r_rd_en   <= 1'b0;
        r_to_cnt  <= '0;
        r_state   <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (bus.RX_D_VLD) begin
            case (bus.RX_P_DATA)
              OP_WR:   r_state <= ST_WR_ADDR;
              OP_RD:   r_state <= ST_RD_ADDR;
              OP_CC:   r_state <= ST_ALU_A;
              OP_DD:   r_state <= ST_ALU_FUN;
              default: r_cmd_err <= 1'b1;
            endcase
          end
          ST_WR_ADDR: if (bus.RX_D_VLD) begin
            r_addr  <= bus.RX_P_DATA[AW-1:0];
            r_state <= ST_WR_DATA;
          end
          ST_WR_DATA: if (bus.RX_D_VLD) begin
            r_wr_en   <= 1'b1;
            r_address <= r_addr;
            r_wr_data <= bus.RX_P_DATA;
            r_state   <= ST_IDLE;
          end
          ST_RD_ADDR: if (bus.RX_D_VLD) begin
            r_rd_en   <= 1'b1;
            r_address <= bus.RX_P_DATA[AW-1:0];
            r_state   <= ST_RD_WAIT;
          end
          ST_RD_WAIT: if (bus.RdData_valid) begin
            r_rd_en  <= 1'b0;
            r_tx_buf <= {{DW{1'b0}}, bus.RdData};
            r_tx_two <= 1'b0;
            r_state  <= ST_TX_LO;
          end
          ST_ALU_A: if (bus.RX_D_VLD) begin
            r_wr_en   <= 1'b1;
            r_address <= AW'(0);
            r_wr_data <= bus.RX_P_DATA;
            r_state   <= ST_ALU_B;
          end
          ST_ALU_B: if (bus.RX_D_VLD) begin
            r_wr_en   <= 1'b1;
            r_address <= AW'(1);
            r_wr_data <= bus.RX_P_DATA;
            r_state   <= ST_ALU_FUN;
          end
          ST_ALU_FUN: if (bus.RX_D_VLD) begin
            r_alu_en  <= 1'b1;
            r_alu_fun <= bus.RX_P_DATA[3:0];
            r_clkg_en <= 1'b1;
            r_state   <= ST_ALU_WAIT;
          end
          ST_ALU_WAIT: if (bus.OUT_valid) begin
            r_clkg_en <= 1'b0;
            r_tx_buf  <= bus.ALU_OUT;
            r_tx_two  <= 1'b1;
            r_state   <= ST_TX_LO;
          end
          ST_TX_LO: if (!bus.FIFO_FULL) begin
            r_wr_inc    <= 1'b1;
            r_fifo_data <= r_tx_buf[DW-1:0];
            r_state     <= r_tx_two ? ST_TX_HI : ST_IDLE;
          end
          ST_TX_HI: if (!bus.FIFO_FULL) begin
            r_wr_inc    <= 1'b1;
            r_fifo_data <= r_tx_buf[2*DW-1:DW];
            r_state     <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.WrEN         = r_wr_en;
  assign bus.RdEN         = r_rd_en;
  assign bus.Address      = r_address;
  assign bus.WrData       = r_wr_data;
  assign bus.ALU_EN       = r_alu_en;
  assign bus.ALU_FUN      = r_alu_fun;
  assign bus.CLKG_EN      = r_clkg_en;
  assign bus.CLKDIV_EN    = r_clkdiv_en;
  assign bus.WR_DATA_FIFO = r_fifo_data;
  assign bus.WR_INC       = r_wr_inc;
  assign bus.CMD_ERR      = r_cmd_err;
  assign o_dbg_state      = r_state;

endmodule
